// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: req/grant arbiter sharing one single-port record BRAM
// between NREQ protocol engines. Round-robin arbitration with requester 0
// winning every arbitration point it takes part in, plus an optional hold
// limit that revokes a long-running grant when somebody else is waiting.
// RAM access outputs are combinational from the registered grant and are
// all-zero whenever no granted requester is actively requesting.
module mem_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*AW-1:0]  i_addr,
  input  logic [NREQ-1:0]     i_we,
  input  logic [NREQ*DW-1:0]  i_wdata,
  output logic [NREQ-1:0]     o_gnt,
  output logic [NREQ-1:0]     o_rvalid,
  output logic [DW-1:0]       o_rdata,
  output logic                o_preempt,
  output logic                o_ram_en,
  output logic                o_ram_we,
  output logic [AW-1:0]       o_ram_addr,
  output logic [DW-1:0]       o_ram_wdata,
  input  logic [DW-1:0]       i_ram_rdata
);

  // Index width for requester numbers.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Hold counter only needs to reach MAX_HOLD-1; it saturates there so the
  // preemption test is a plain equality.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // --------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------
  state_t             state_q;
  logic [NREQ-1:0]    gnt_q;
  logic [IW-1:0]      last_owner_q;
  logic [HW-1:0]      hold_q;
  logic               preempt_q;
  logic [NREQ-1:0]    rvalid_q;

  // --------------------------------------------------------------------
  // Arbitration helpers
  // --------------------------------------------------------------------
  logic               owner_req;
  logic               others_req;
  logic               hold_full;
  logic               preempt_fire;
  logic               arb_point;
  logic [NREQ-1:0]    cand;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [NREQ-1:0]    gnt_d;
  logic [NREQ-1:0]    rvalid_d;

  // Access selection and per-requester masked buses
  logic [NREQ-1:0]    acc_sel;
  logic [AW-1:0]      addr_m  [NREQ];
  logic [DW-1:0]      wdata_m [NREQ];
  logic [NREQ-1:0]    we_m;
  logic [AW-1:0]      ram_addr_d;
  logic [DW-1:0]      ram_wdata_d;

  genvar gi;

  // Position base+off modulo NREQ, with off in 1..NREQ.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return IW'(sum);
  endfunction

  // The current owner is the single set grant bit; it is still requesting
  // when that bit lines up with its request.
  assign owner_req    = |(gnt_q & i_req);
  assign others_req   = |(i_req & ~gnt_q);
  assign hold_full    = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);
  assign preempt_fire = owner_req && hold_full && others_req;
  assign arb_point    = (state_q == ST_IDLE) || !owner_req || preempt_fire;

  // The releasing or revoked owner never competes at its own release edge.
  assign cand = i_req & ~gnt_q;

  // Requester 0 first, otherwise round-robin upward from last_owner+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (cand[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        if (!win_found && cand[wrap_idx(last_owner_q, off)]) begin
          win_found = 1'b1;
          win_idx   = wrap_idx(last_owner_q, off);
        end
      end
    end
  end

  // One-hot image of the winner, loaded directly at the arbitration edge.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign gnt_d[gi] = win_found && (win_idx == IW'(gi));
    end
  endgenerate

  // Grant FSM: owns grant, last owner, hold counter and preempt pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      last_owner_q <= IW'(NREQ - 1);
      hold_q       <= '0;
      preempt_q    <= 1'b0;
    end else begin
      preempt_q <= preempt_fire;
      if (arb_point) begin
        hold_q <= '0;
        gnt_q  <= gnt_d;
        if (win_found) begin
          state_q      <= ST_OWNED;
          last_owner_q <= win_idx;
        end else begin
          state_q <= ST_IDLE;
        end
      end else if (hold_q != HOLD_SAT) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------
  // RAM access path
  // --------------------------------------------------------------------

  // Nothing reaches the RAM while reset is held.
  assign acc_sel = i_rst ? '0 : (gnt_q & i_req);

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_acc
      assign addr_m[gi]  = acc_sel[gi] ? i_addr[gi*AW +: AW]  : '0;
      assign wdata_m[gi] = acc_sel[gi] ? i_wdata[gi*DW +: DW] : '0;
      assign we_m[gi]    = acc_sel[gi] & i_we[gi];
    end
  endgenerate

  // AND-OR mux of the selected requester onto the RAM bus (at most one
  // select bit is ever set, so the OR is a clean mux with zero idle value).
  always_comb begin
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      ram_addr_d  = ram_addr_d  | addr_m[k];
      ram_wdata_d = ram_wdata_d | wdata_m[k];
    end
  end

  // A granted read this cycle returns its data next cycle.
  assign rvalid_d = acc_sel & ~i_we;

  // Read-return tag register; independent of later grant changes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign o_gnt       = gnt_q;
  assign o_rvalid    = rvalid_q;
  assign o_preempt   = preempt_q;
  assign o_rdata     = i_ram_rdata;
  assign o_ram_en    = |acc_sel;
  assign o_ram_we    = |we_m;
  assign o_ram_addr  = ram_addr_d;
  assign o_ram_wdata = ram_wdata_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives two arbiters (hold limit 4 and hold limit 0)
// with the same request stream, each attached to its own behavioural BRAM.
// A reference model advances once per clock edge; read responses go into a
// scoreboard queue that a separate monitor drains when o_rvalid appears.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [3:0]  gnt    [2];
  logic [3:0]  rvalid [2];
  logic [7:0]  rdata  [2];
  logic        pre    [2];
  logic        ren    [2];
  logic        rwe    [2];
  logic [7:0]  raddr  [2];
  logic [7:0]  rwd    [2];

  int n_vec;
  int n_err;
  int cyc;

  typedef struct {
    int         k;
    logic [7:0] d;
    int         due;
  } rd_t;

  rd_t q0[$];
  rd_t q1[$];

  // Reference model state: owner index (-1 = nobody), last owner, cycles held.
  int         m_owner [2];
  int         m_last  [2];
  int         m_hold  [2];
  bit         m_pre   [2];
  int         maxh    [2];
  logic [7:0] ref_mem [2][256];

  genvar gi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [7:0] ram [256];
      logic [7:0] ram_q;

      initial begin
        for (int k = 0; k < 256; k++) ram[k] = 8'(k) ^ 8'hA0;
      end

      always @(posedge clk) begin
        if (ren[gi]) begin
          if (rwe[gi]) ram[raddr[gi]] <= rwd[gi];
          ram_q <= ram[raddr[gi]];
        end
      end

      mem_port_arbiter #(
        .NREQ(4), .AW(8), .DW(8), .MAX_HOLD(gi == 0 ? 4 : 0)
      ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_addr      (addr),
        .i_we        (we),
        .i_wdata     (wdata),
        .o_gnt       (gnt[gi]),
        .o_rvalid    (rvalid[gi]),
        .o_rdata     (rdata[gi]),
        .o_preempt   (pre[gi]),
        .o_ram_en    (ren[gi]),
        .o_ram_we    (rwe[gi]),
        .o_ram_addr  (raddr[gi]),
        .o_ram_wdata (rwd[gi]),
        .i_ram_rdata (ram_q)
      );
    end
  endgenerate

  // Compare the cycle-level outputs of both arbiters against the model.
  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      int         o;
      bit         acc;
      logic [3:0] eg;
      logic [17:0] eram;
      logic [17:0] gram;
      o   = m_owner[i];
      eg  = (o < 0) ? 4'b0000 : 4'(1 << o);
      acc = !rst && (o >= 0) && req[o];
      if (acc)
        eram = {1'b1, we[o], addr[o*8 +: 8], wdata[o*8 +: 8]};
      else
        eram = '0;
      gram = {ren[i], rwe[i], raddr[i], rwd[i]};
      n_vec++;
      if (gnt[i] !== eg) begin
        n_err++;
        $display("FAIL gnt inst%0d cyc%0d: got %b expected %b", i, cyc, gnt[i], eg);
      end
      n_vec++;
      if (gram !== eram) begin
        n_err++;
        $display("FAIL ram_bus inst%0d cyc%0d: got en/we/addr/wdata %h expected %h", i, cyc, gram, eram);
      end
      n_vec++;
      if (pre[i] !== m_pre[i]) begin
        n_err++;
        $display("FAIL preempt inst%0d cyc%0d: got %b expected %b", i, cyc, pre[i], m_pre[i]);
      end
    end
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int  o;
      int  win;
      bit  acc;
      bit  others;
      bit  rel;
      bit  rev;
      rd_t e;
      o = m_owner[i];
      if (rst) begin
        m_owner[i] = -1;
        m_last[i]  = 3;
        m_hold[i]  = 0;
        m_pre[i]   = 1'b0;
        continue;
      end
      acc = (o >= 0) && req[o];
      if (acc) begin
        if (we[o]) begin
          ref_mem[i][addr[o*8 +: 8]] = wdata[o*8 +: 8];
        end else begin
          e.k   = o;
          e.d   = ref_mem[i][addr[o*8 +: 8]];
          e.due = cyc + 1;
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
      others = 1'b0;
      for (int k = 0; k < 4; k++) if (k != o && req[k]) others = 1'b1;
      rel = (o >= 0) && !req[o];
      rev = acc && (maxh[i] > 0) && (m_hold[i] >= maxh[i] - 1) && others;
      m_pre[i] = rev;
      if (o < 0 || rel || rev) begin
        win = -1;
        if (req[0] && o != 0) begin
          win = 0;
        end else begin
          for (int off = 1; off <= 4; off++) begin
            int j;
            j = (m_last[i] + off) % 4;
            if (win < 0 && req[j] && j != o) win = j;
          end
        end
        m_owner[i] = win;
        m_hold[i]  = 0;
        if (win >= 0) m_last[i] = win;
      end else begin
        m_hold[i] = m_hold[i] + 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic drive(input bit r, input logic [3:0] rq, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    rst   = r;
    req   = rq;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  // Scoreboard side: pop one expected read each time o_rvalid shows up,
  // and flag any expected read whose cycle passes without it.
  task automatic mon_check(input int i);
    rd_t        e;
    int         n;
    logic [3:0] rv;
    rv = rvalid[i];
    n  = (i == 0) ? q0.size() : q1.size();
    if (n > 0) e = (i == 0) ? q0[0] : q1[0];
    if (rv !== 4'b0000 || (n > 0 && e.due <= cyc)) begin
      n_vec++;
      if (n == 0) begin
        n_err++;
        $display("FAIL rvalid inst%0d cyc%0d: got unexpected rvalid %b rdata %h, expected none", i, cyc, rv, rdata[i]);
      end else begin
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        if (rv !== 4'(1 << e.k) || rdata[i] !== e.d || e.due != cyc) begin
          n_err++;
          $display("FAIL rvalid inst%0d cyc%0d: got rvalid %b rdata %h, expected rvalid %b rdata %h due cyc%0d",
                   i, cyc, rv, rdata[i], 4'(1 << e.k), e.d, e.due);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      mon_check(0);
      mon_check(1);
    end
  end

  initial begin
    logic [3:0]  rq;
    logic [31:0] a;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    maxh[0] = 4;
    maxh[1] = 0;
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 3;
      m_hold[i]  = 0;
      m_pre[i]   = 1'b0;
      for (int k = 0; k < 256; k++) ref_mem[i][k] = 8'(k) ^ 8'hA0;
    end
    drive(1'b1, 4'b0000, 4'b0000, 32'h0, 32'h0);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    tick();                                   // reset state visible

    // Single requester 2 reads 0x05 then 0x06.
    drive(1'b0, 4'b0100, 4'b0000, 32'h0005_0000, 32'h0);
    tick();
    tick();
    addr = 32'h0006_0000;
    tick();
    req = 4'b0000;
    repeat (3) tick();

    // Round-robin 1,2,3,1, each owner releasing after three accesses.
    drive(1'b1, 4'b0000, 4'b0000, 32'h0302_0100, 32'h0);
    tick();
    drive(1'b0, 4'b1110, 4'b0000, 32'h0302_0100, 32'h0);
    repeat (4) tick();
    req = 4'b1100; tick();
    req = 4'b1110; repeat (3) tick();
    req = 4'b1010; tick();
    req = 4'b1110; repeat (3) tick();
    req = 4'b0110; tick();
    req = 4'b0010; repeat (2) tick();
    req = 4'b0000; repeat (2) tick();

    // Owner 3, then requesters 0 and 1 raise; 0 wins once 3 lets go.
    drive(1'b0, 4'b1000, 4'b0000, 32'h0908_0706, 32'h0);
    repeat (2) tick();
    req = 4'b1011; repeat (2) tick();
    req = 4'b0011; repeat (2) tick();
    req = 4'b0000; repeat (2) tick();

    // Hold limit: requester 1 holds, requester 2 waits.
    drive(1'b1, 4'b0000, 4'b0000, 32'h0, 32'h0);
    tick();
    drive(1'b0, 4'b0010, 4'b0000, 32'h0020_2100, 32'h0);
    tick();
    req = 4'b0110; repeat (8) tick();
    req = 4'b0000; repeat (2) tick();

    // Requester 1 writes 0x3C to 0x10, requester 2 reads it back.
    drive(1'b0, 4'b0010, 4'b0010, 32'h0010_1000, 32'h0000_3C00);
    repeat (2) tick();
    drive(1'b0, 4'b0100, 4'b0000, 32'h0010_1000, 32'h0);
    repeat (2) tick();
    req = 4'b0000; repeat (2) tick();

    // Reset in the middle of requester 3's read stream.
    drive(1'b0, 4'b1000, 4'b0000, 32'h4000_0000, 32'h0);
    repeat (3) tick();
    addr = 32'h4100_0000; tick();
    drive(1'b1, 4'b1010, 4'b0000, 32'h4200_0100, 32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    req = 4'b0000; repeat (2) tick();

    // Random traffic on a small address window for read-after-write hits.
    rq = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) rq[k] = ~rq[k];
      a = $urandom & 32'h0F0F_0F0F;
      drive(($urandom_range(0, 199) == 0), rq, 4'($urandom), a, $urandom);
      tick();
    end

    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 32'h0);
    repeat (4) tick();
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d reads still pending, expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port record BRAM (8-bit address, 8-bit data, 1-cycle read latency) between up to NREQ requesters: Ethernet frame loader, message writer, header reader, command processor and checksum engine. It replaces the OR-combined address/data/write-enable buses with an explicit req/grant handshake. Arbitration is round-robin with a fixed-priority override for requester 0 and an optional hold limit. It sits between the protocol engines in the frame-handling top level and the `bram` instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- AW, 8: RAM address width.
- DW, 8: RAM data width.
- MAX_HOLD, 64: maximum consecutive granted cycles before preemption when another requester is waiting; 0 disables preemption.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  NREQ  per-requester access request, level.
- i_addr  in  NREQ*AW  requester k address at [k*AW +: AW].
- i_we  in  NREQ  per-requester write enable.
- i_wdata  in  NREQ*DW  requester k write data at [k*DW +: DW].
- o_gnt  out  NREQ  registered one-hot grant.
- o_rvalid  out  NREQ  one-cycle pulse: o_rdata holds read data for requester k.
- o_rdata  out  DW  RAM read data, broadcast to all requesters.
- o_preempt  out  1  one-cycle pulse when a grant is revoked by the hold limit.
- o_ram_en  out  1  RAM enable.
- o_ram_we  out  1  RAM write enable.
- o_ram_addr  out  AW  RAM address.
- o_ram_wdata  out  DW  RAM write data.
- i_ram_rdata  in  DW  RAM output data.

## Operation
- States: IDLE (o_gnt = 0) and OWNED (exactly one o_gnt bit set).
- Arbitration point: any edge in IDLE, or any edge in OWNED where the owner's i_req is low or preemption fires.
  - Winner is requester 0 if i_req[0] is high.
  - Otherwise the first requesting index searching upward (with wrap) from last_owner+1.
  - The revoked or releasing owner is excluded from the candidate set at that edge.
  - With no candidate, go to IDLE.
- Handover has no bubble: the releasing edge loads the new winner's grant directly.
- Access: when o_gnt[k] & i_req[k]:
  - o_ram_en = 1, o_ram_addr = i_addr[k], o_ram_we = i_we[k], o_ram_wdata = i_wdata[k].
  - These are combinational from the registered grant.
- Otherwise o_ram_en = o_ram_we = 0 and o_ram_addr = o_ram_wdata = 0. This preserves the all-zero idle contract of the old OR bus.
- Read return: a granted access with i_we[k] = 0 in cycle t asserts o_rvalid[k] in cycle t+1. o_rdata = i_ram_rdata, passthrough.
- Hold counter: cleared on every new grant, incremented each OWNED cycle, saturating.
- Preemption: MAX_HOLD ≠ 0, counter = MAX_HOLD-1, and any other i_req high. At that edge:
  - The grant moves to the next winner.
  - o_preempt pulses.
  - The revoked requester must keep i_req high to be re-queued.
- Requester 0 never preempts an owner. It only wins at arbitration points.
- last_owner is updated on every new grant.

## Timing
- Reset values:
  - o_gnt = 0, o_rvalid = 0, o_preempt = 0, o_ram_en = 0, o_ram_we = 0, o_ram_addr = 0, o_ram_wdata = 0.
  - last_owner = NREQ-1, so the first round-robin search starts at index 0.
  - Hold counter = 0, state IDLE.
- Request-to-grant latency: i_req[k] high at edge n (IDLE) → o_gnt[k] high after edge n. First RAM access is in that same cycle if i_req[k] is still high.
- Release: the owner drops i_req in cycle t. No access occurs in t, since access is gated by i_req. o_gnt clears or transfers at the end of t.
- Write lands in the cycle it is presented. Read data is valid one cycle later with o_rvalid.
- An o_rvalid already in flight is still delivered after a grant change or preemption.
- Reset mid-burst:
  - All outputs are zero in the cycle after the reset edge.
  - A pending o_rvalid is dropped.
  - No RAM write occurs while i_rst is high.
- Simultaneous requests at a single edge follow the priority rules above. Ties cannot occur because the choice is deterministic.

## Test plan
- Single requester: i_req[2] = 1 with reads of addr 0x05 then 0x06 (RAM preloaded 0xA5, 0xA6) → o_gnt = 4'b0100 one cycle after the request, o_rvalid[2] pulses with o_rdata = 0xA5 then 0xA6, o_ram_en low after release.
- Round-robin: i_req = 4'b1110 held, each owner releasing after 3 accesses → grant order 1, 2, 3, 1, with zero idle cycles between owners.
- Priority: owner 3 active, i_req[0] and i_req[1] raised → no preemption; after 3 drops, o_gnt = 4'b0001.
- Preemption with MAX_HOLD = 4: requester 1 holds the grant, requester 2 requests → after 4 granted cycles o_gnt = 4'b0100 and o_preempt is a single-cycle pulse. MAX_HOLD = 0 → no transfer.
- Write/read mix: requester 1 writes 0x3C to 0x10, requester 2 then reads 0x10 → o_rdata = 0x3C with o_rvalid[2]. o_rvalid[1] is never asserted for the write.
- Reset mid-burst: i_rst pulsed during requester 3's read stream → next cycle all outputs are 0, no o_rvalid, and o_gnt re-arbitrates from index 0.
